// File: rtl/conv_out_align_buffer_pkg.sv
// rtl/conv_out_align_buffer_pkg.sv - shared state encoding and width helper for the conv output align buffer
package conv_out_align_buffer_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Never returns less than 1 so single-entry counters still get a real bit.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/conv_out_align_buffer_if.sv
// rtl/conv_out_align_buffer_if.sv - input/output handshake bundle of the conv output align buffer
interface conv_out_align_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  overflow;

    modport master (
        output valid_in, pxl_in, ready_out,
        input  ready_in, pxl_out, valid_out, overflow
    );

    modport slave (
        input  valid_in, pxl_in, ready_out,
        output ready_in, pxl_out, valid_out, overflow
    );
endinterface

// File: rtl/conv_align_ram.sv
// rtl/conv_align_ram.sv - simple dual-port RAM, one write port and one combinational read port
module conv_align_ram
    import conv_out_align_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/conv_out_align_buffer.sv
// rtl/conv_out_align_buffer.sv - collects NUM_BANK banks of BANK_DEPTH words, drains bank-major or interleaved
// Optional macro CONV_ALIGN_RELU_EN: zero negative words on the output register.
module conv_out_align_buffer
    import conv_out_align_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANK   = 8,
    parameter int BANK_DEPTH = 64,
    parameter int OUT_ORDER  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    conv_out_align_buffer_if.slave   bus
);
    localparam int ALIGN_SIZE     = NUM_BANK * BANK_DEPTH;
    localparam int ADDR_WIDTH     = clog2(ALIGN_SIZE);
    localparam int BANK_CNT_WIDTH = clog2(NUM_BANK);
    localparam int WORD_CNT_WIDTH = clog2(BANK_DEPTH);

    localparam logic [BANK_CNT_WIDTH-1:0] LAST_BANK = BANK_CNT_WIDTH'(NUM_BANK - 1);
    localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD = WORD_CNT_WIDTH'(BANK_DEPTH - 1);

    state_t state_q, state_d;

    logic [BANK_CNT_WIDTH-1:0] wr_bank_q, rd_bank_q;
    logic [WORD_CNT_WIDTH-1:0] wr_word_q, rd_word_q;
    logic                      rd_done_q;

    logic                  wr_en, wr_last, rd_last, rd_issue, rd_finish;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] rd_data, load_data;

    assign wr_last = (wr_bank_q == LAST_BANK) && (wr_word_q == LAST_WORD);
    assign rd_last = (rd_bank_q == LAST_BANK) && (rd_word_q == LAST_WORD);

    // Both drain orders share the bank/word address form; only the counter nesting differs.
    assign wr_addr = ADDR_WIDTH'(wr_bank_q) * ADDR_WIDTH'(BANK_DEPTH) + ADDR_WIDTH'(wr_word_q);
    assign rd_addr = ADDR_WIDTH'(rd_bank_q) * ADDR_WIDTH'(BANK_DEPTH) + ADDR_WIDTH'(rd_word_q);

    always_comb begin
        state_d      = state_q;
        wr_en        = 1'b0;
        rd_issue     = 1'b0;
        rd_finish    = 1'b0;
        bus.ready_in = 1'b0;
        case (state_q)
            ST_FILL: begin
                bus.ready_in = 1'b1;
                if (bus.valid_in) begin
                    wr_en = 1'b1;
                    if (wr_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.valid_out || bus.ready_out) begin
                    if (!rd_done_q) begin
                        rd_issue = 1'b1;
                    end else begin
                        rd_finish = 1'b1;
                        state_d   = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= '0;
            wr_word_q <= '0;
        end else if (wr_en) begin
            if (wr_last) begin
                wr_bank_q <= '0;
                wr_word_q <= '0;
            end else if (wr_word_q == LAST_WORD) begin
                wr_word_q <= '0;
                wr_bank_q <= wr_bank_q + 1'b1;
            end else begin
                wr_word_q <= wr_word_q + 1'b1;
            end
        end
    end

    // rd_done_q marks the final word as loaded; the set closes when it is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank_q <= '0;
            rd_word_q <= '0;
            rd_done_q <= 1'b0;
        end else if (rd_issue) begin
            if (rd_last) begin
                rd_bank_q <= '0;
                rd_word_q <= '0;
                rd_done_q <= 1'b1;
            end else if (OUT_ORDER == 0) begin
                if (rd_word_q == LAST_WORD) begin
                    rd_word_q <= '0;
                    rd_bank_q <= rd_bank_q + 1'b1;
                end else begin
                    rd_word_q <= rd_word_q + 1'b1;
                end
            end else begin
                if (rd_bank_q == LAST_BANK) begin
                    rd_bank_q <= '0;
                    rd_word_q <= rd_word_q + 1'b1;
                end else begin
                    rd_bank_q <= rd_bank_q + 1'b1;
                end
            end
        end else if (rd_finish) begin
            rd_done_q <= 1'b0;
        end
    end

    always_comb begin
        load_data = rd_data;
`ifdef CONV_ALIGN_RELU_EN
        if (rd_data[DATA_WIDTH-1]) begin
            load_data = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pxl_out   <= '0;
            bus.valid_out <= 1'b0;
        end else if (rd_issue) begin
            bus.pxl_out   <= load_data;
            bus.valid_out <= 1'b1;
        end else if (rd_finish) begin
            bus.valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.overflow <= 1'b0;
        end else if ((state_q == ST_DRAIN) && bus.valid_in) begin
            bus.overflow <= 1'b1;
        end
    end

    conv_align_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (ALIGN_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.pxl_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule
